// File: rtl/video_color_pkg.sv
// Shared types and constants for the streaming colour transform.
package video_color_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_LUMA   = 2'd1,
        MODE_AVG    = 2'd2,
        MODE_INVERT = 2'd3
    } mode_e;

    // Weights as 8-bit fractions (x/256); scaled up when WSIZE is wider.
    localparam int LUMA_RW = 53;
    localparam int LUMA_GW = 184;
    localparam int LUMA_BW = 18;
    localparam int AVG_W   = 85;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/video_color_wsum.sv
// Registered weighted sum of three CW-bit channels, shifted by WSIZE and saturated.
// VIDEO_COLOR_XFORM_ROUND_EN selects round-half-up instead of truncation.
module video_color_wsum
    import video_color_pkg::*;
#(
    parameter int CW    = 4,
    parameter int WSIZE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [CW-1:0]    i_r,
    input  logic [CW-1:0]    i_g,
    input  logic [CW-1:0]    i_b,
    input  logic [WSIZE-1:0] i_rw,
    input  logic [WSIZE-1:0] i_gw,
    input  logic [WSIZE-1:0] i_bw,
    output logic [CW-1:0]    o_gray
);
    // Two guard bits hold 3 * (2^CW-1) * (2^WSIZE-1) plus the rounding term.
    localparam int SW = CW + WSIZE + 2;

    logic [SW-1:0] w_sum;
    logic [SW-1:0] w_shift;
    logic          w_sat;
    logic [CW-1:0] r_gray;

    always_comb begin
        w_sum = SW'(i_r) * SW'(i_rw) + SW'(i_g) * SW'(i_gw) + SW'(i_b) * SW'(i_bw);
`ifdef VIDEO_COLOR_XFORM_ROUND_EN
        w_sum = w_sum + (SW'(1) << (WSIZE - 1));
`else
        w_sum = w_sum;
`endif
        w_shift = w_sum >> WSIZE;
    end

    assign w_sat = |w_shift[SW-1:CW];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gray <= '0;
        end else if (i_en) begin
            r_gray <= w_sat ? {CW{1'b1}} : w_shift[CW-1:0];
        end
    end

    assign o_gray = r_gray;

endmodule

// File: rtl/video_color_xform_gen.sv
// Two-stage streaming colour transform (bypass / luma gray / average gray / invert)
// with frame-synchronous config. VIDEO_COLOR_XFORM_ROUND_EN enables rounding in the gray path.
module video_color_xform_gen
    import video_color_pkg::*;
#(
    parameter int RSIZE    = 4,
    parameter int GSIZE    = 4,
    parameter int BSIZE    = 4,
    parameter int RGB_SIZE = RSIZE + GSIZE + BSIZE,
    parameter int WSIZE    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          cfg_mode,
    input  logic [WSIZE-1:0]    cfg_rw,
    input  logic [WSIZE-1:0]    cfg_gw,
    input  logic [WSIZE-1:0]    cfg_bw,
    input  logic                src_valid,
    output logic                src_ready,
    input  logic                src_sof,
    input  logic                src_eol,
    input  logic [RGB_SIZE-1:0] src_rgb,
    output logic                snk_valid,
    input  logic                snk_ready,
    output logic                snk_sof,
    output logic                snk_eol,
    output logic [RGB_SIZE-1:0] snk_rgb
);
    localparam int CW     = max3(RSIZE, GSIZE, BSIZE);
    localparam int STAGES = 2;
    localparam logic [WSIZE-1:0] DEF_RW = WSIZE'(LUMA_RW << (WSIZE - 8));
    localparam logic [WSIZE-1:0] DEF_GW = WSIZE'(LUMA_GW << (WSIZE - 8));
    localparam logic [WSIZE-1:0] DEF_BW = WSIZE'(LUMA_BW << (WSIZE - 8));
    localparam logic [WSIZE-1:0] AVG_WS = WSIZE'(AVG_W << (WSIZE - 8));

    mode_e               r_mode;
    logic [WSIZE-1:0]    r_rw, r_gw, r_bw;
    logic [STAGES:1]     r_vld_pipe;
    logic                r_s0_sof, r_s0_eol;
    mode_e               r_s0_mode;
    logic [RGB_SIZE-1:0] r_s0_rgb;
    logic [CW-1:0]       r_s0_r, r_s0_g, r_s0_b;
    logic [WSIZE-1:0]    r_s0_rw, r_s0_gw, r_s0_bw;
    logic                r_s1_sof, r_s1_eol, r_s1_gray;
    logic [RGB_SIZE-1:0] r_s1_rgb;

    logic                w_en, w_acc, w_latch;
    mode_e               w_mode;
    logic [WSIZE-1:0]    w_rw, w_gw, w_bw;
    logic [CW-1:0]       w_r, w_g, w_b;
    logic [CW-1:0]       w_gray;

    assign w_en      = !r_vld_pipe[STAGES] || snk_ready;
    assign w_acc     = src_valid && w_en;
    assign w_latch   = w_acc && src_sof;
    assign src_ready = w_en;

    // The sof beat itself already uses the config it latches.
    always_comb begin
        w_mode = w_latch ? mode_e'(cfg_mode) : r_mode;
        w_rw   = w_latch ? cfg_rw : r_rw;
        w_gw   = w_latch ? cfg_gw : r_gw;
        w_bw   = w_latch ? cfg_bw : r_bw;
        if (w_mode == MODE_AVG) begin
            w_rw = AVG_WS;
            w_gw = AVG_WS;
            w_bw = AVG_WS;
        end
    end

    assign w_r = CW'(src_rgb[RGB_SIZE-1 -: RSIZE]) << (CW - RSIZE);
    assign w_g = CW'(src_rgb[GSIZE+BSIZE-1 -: GSIZE]) << (CW - GSIZE);
    assign w_b = CW'(src_rgb[BSIZE-1:0]) << (CW - BSIZE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= MODE_BYPASS;
            r_rw   <= DEF_RW;
            r_gw   <= DEF_GW;
            r_bw   <= DEF_BW;
        end else if (w_latch) begin
            r_mode <= mode_e'(cfg_mode);
            r_rw   <= cfg_rw;
            r_gw   <= cfg_gw;
            r_bw   <= cfg_bw;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_s0_sof   <= 1'b0;
            r_s0_eol   <= 1'b0;
            r_s0_mode  <= MODE_BYPASS;
            r_s0_rgb   <= '0;
            r_s0_r     <= '0;
            r_s0_g     <= '0;
            r_s0_b     <= '0;
            r_s0_rw    <= '0;
            r_s0_gw    <= '0;
            r_s0_bw    <= '0;
            r_s1_sof   <= 1'b0;
            r_s1_eol   <= 1'b0;
            r_s1_gray  <= 1'b0;
            r_s1_rgb   <= '0;
        end else if (w_en) begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], src_valid};
            r_s0_sof   <= src_valid && src_sof;
            r_s0_eol   <= src_valid && src_eol;
            r_s0_mode  <= w_mode;
            r_s0_rgb   <= src_rgb;
            r_s0_r     <= w_r;
            r_s0_g     <= w_g;
            r_s0_b     <= w_b;
            r_s0_rw    <= w_rw;
            r_s0_gw    <= w_gw;
            r_s0_bw    <= w_bw;
            r_s1_sof   <= r_s0_sof;
            r_s1_eol   <= r_s0_eol;
            r_s1_gray  <= (r_s0_mode == MODE_LUMA) || (r_s0_mode == MODE_AVG);
            r_s1_rgb   <= (r_s0_mode == MODE_INVERT) ? ~r_s0_rgb : r_s0_rgb;
        end
    end

    video_color_wsum #(
        .CW    (CW),
        .WSIZE (WSIZE)
    ) u_wsum (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_en),
        .i_r    (r_s0_r),
        .i_g    (r_s0_g),
        .i_b    (r_s0_b),
        .i_rw   (r_s0_rw),
        .i_gw   (r_s0_gw),
        .i_bw   (r_s0_bw),
        .o_gray (w_gray)
    );

    assign snk_valid = r_vld_pipe[STAGES];
    assign snk_sof   = r_s1_sof;
    assign snk_eol   = r_s1_eol;
    assign snk_rgb   = r_s1_gray ? {w_gray[CW-1 -: RSIZE], w_gray[CW-1 -: GSIZE], w_gray[CW-1 -: BSIZE]}
                                 : r_s1_rgb;

endmodule

// File: tb/tb_video_color_xform_gen.sv
// Bench for video_color_xform_gen (default 4/4/4, WSIZE=8): directed cases plus a
// random stream scored against a queue-based reference model.
module tb_video_color_xform_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_rw, cfg_gw, cfg_bw;
    logic        src_valid, src_ready, src_sof, src_eol;
    logic [11:0] src_rgb;
    logic        snk_valid, snk_ready, snk_sof, snk_eol;
    logic [11:0] snk_rgb;

    video_color_xform_gen dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_mode  (cfg_mode),
        .cfg_rw    (cfg_rw),
        .cfg_gw    (cfg_gw),
        .cfg_bw    (cfg_bw),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_sof   (src_sof),
        .src_eol   (src_eol),
        .src_rgb   (src_rgb),
        .snk_valid (snk_valid),
        .snk_ready (snk_ready),
        .snk_sof   (snk_sof),
        .snk_eol   (snk_eol),
        .snk_rgb   (snk_rgb)
    );

    always #5 clk = ~clk;

`ifdef VIDEO_COLOR_XFORM_ROUND_EN
    localparam int RND = 128;
    localparam logic [11:0] EXP_WHITE = 12'hFFF;
    localparam logic [11:0] EXP_AVG   = 12'h666;
`else
    localparam int RND = 0;
    localparam logic [11:0] EXP_WHITE = 12'hEEE;
    localparam logic [11:0] EXP_AVG   = 12'h555;
`endif

    typedef struct {
        logic [11:0] rgb;
        logic        sof;
        logic        eol;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;
    int   n_acc = 0;
    int   n_out = 0;
    int   m_mode = 0;
    int   m_rw = 53, m_gw = 184, m_bw = 18;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: gray = min(weighted_sum / 256, 15) replicated on all three channels.
    function automatic logic [11:0] model(input int mode, input int rw, input int gw,
                                          input int bw, input logic [11:0] p);
        int r, g, b, s, gr;
        r = int'(p[11:8]);
        g = int'(p[7:4]);
        b = int'(p[3:0]);
        if (mode == 0) return p;
        if (mode == 3) return ~p;
        if (mode == 1) s = r * rw + g * gw + b * bw;
        else           s = (r + g + b) * 85;
        gr = (s + RND) / 256;
        if (gr > 15) gr = 15;
        return {gr[3:0], gr[3:0], gr[3:0]};
    endfunction

    // One clock: score the outgoing beat, log the incoming beat, check stall hold.
    task automatic tick();
        logic acc, xfer, hold, h_sof, h_eol;
        logic [11:0] h_rgb;
        exp_t e;
        #1;
        acc   = src_valid && src_ready && !rst;
        xfer  = snk_valid && snk_ready && !rst;
        hold  = snk_valid && !snk_ready && !rst;
        h_rgb = snk_rgb;
        h_sof = snk_sof;
        h_eol = snk_eol;
        if (xfer) begin
            n_out++;
            chk("out_expected", 32'(expq.size() != 0), 1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("out_rgb", 32'(snk_rgb), 32'(e.rgb));
                chk("out_sof", 32'(snk_sof), 32'(e.sof));
                chk("out_eol", 32'(snk_eol), 32'(e.eol));
            end
        end
        if (acc) begin
            n_acc++;
            if (src_sof) begin
                m_mode = int'(cfg_mode);
                m_rw = int'(cfg_rw); m_gw = int'(cfg_gw); m_bw = int'(cfg_bw);
            end
            e.rgb = model(m_mode, m_rw, m_gw, m_bw, src_rgb);
            e.sof = src_sof;
            e.eol = src_eol;
            expq.push_back(e);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            expq.delete();
            m_mode = 0; m_rw = 53; m_gw = 184; m_bw = 18;
        end
        if (hold) begin
            chk("hold_vld", 32'(snk_valid), 1);
            chk("hold_rgb", 32'(snk_rgb), 32'(h_rgb));
            chk("hold_sof", 32'(snk_sof), 32'(h_sof));
            chk("hold_eol", 32'(snk_eol), 32'(h_eol));
        end
    endtask

    task automatic directed(input string tag, input logic [1:0] mode, input logic sof,
                            input logic [11:0] pix, input logic [11:0] exp);
        cfg_mode = mode; src_sof = sof; src_eol = 1'b0; src_rgb = pix;
        src_valid = 1'b1; snk_ready = 1'b1;
        #1 chk({tag, "_src_ready"}, 32'(src_ready), 1);
        tick();
        src_valid = 1'b0; src_sof = 1'b0;
        chk({tag, "_lat1_vld"}, 32'(snk_valid), 0);
        tick();
        chk({tag, "_lat2_vld"}, 32'(snk_valid), 1);
        chk({tag, "_rgb"}, 32'(snk_rgb), 32'(exp));
        tick();
    endtask

    logic [11:0] spix [10];

    initial begin
        int k, acc0, out0;
        rst = 1'b1; cfg_mode = 2'd0; cfg_rw = 8'd53; cfg_gw = 8'd184; cfg_bw = 8'd18;
        src_valid = 1'b0; src_sof = 1'b0; src_eol = 1'b0; src_rgb = '0; snk_ready = 1'b1;
        tick();
        tick();
        chk("rst_vld", 32'(snk_valid), 0);
        chk("rst_sof", 32'(snk_sof), 0);
        chk("rst_eol", 32'(snk_eol), 0);
        chk("rst_rgb", 32'(snk_rgb), 0);
        rst = 1'b0;
        tick();

        directed("luma_white", 2'd1, 1'b1, 12'hFFF, EXP_WHITE);
        directed("luma_red",   2'd1, 1'b0, 12'hF00, 12'h333);
        directed("avg",        2'd2, 1'b1, 12'h963, EXP_AVG);
        directed("invert",     2'd3, 1'b1, 12'h1A5, 12'hE5A);
        directed("bypass",     2'd0, 1'b1, 12'h1A5, 12'h1A5);
        directed("midframe",   2'd3, 1'b0, 12'h123, 12'h123);
        directed("sof_inv",    2'd3, 1'b1, 12'h123, 12'hEDC);

        cfg_rw = 8'd255; cfg_gw = 8'd255; cfg_bw = 8'd255;
        directed("sat",   2'd1, 1'b1, 12'hFFF, 12'hFFF);
        directed("sat_2", 2'd1, 1'b0, 12'h888, 12'hFFF);
        cfg_rw = 8'd0; cfg_gw = 8'd0; cfg_bw = 8'd0;
        directed("zero_w", 2'd1, 1'b1, 12'hFFF, 12'h000);
        cfg_rw = 8'd53; cfg_gw = 8'd184; cfg_bw = 8'd18;

        // Sof presented under backpressure with a config that changes before acceptance.
        snk_ready = 1'b0; src_valid = 1'b1; src_sof = 1'b1; cfg_mode = 2'd0; src_rgb = 12'h321;
        tick();
        src_sof = 1'b0; src_rgb = 12'h456;
        tick();
        src_sof = 1'b1; cfg_mode = 2'd3; src_rgb = 12'h9A7;
        chk("bp_src_ready", 32'(src_ready), 0);
        tick();
        tick();
        cfg_mode = 2'd1; snk_ready = 1'b1;
        tick();
        src_sof = 1'b1; cfg_mode = 2'd2; src_rgb = 12'hC48;
        tick();
        src_sof = 1'b1; cfg_mode = 2'd3; src_rgb = 12'h5F0;
        tick();
        src_valid = 1'b0; src_sof = 1'b0;
        repeat (4) tick();
        chk("bp_drained", 32'(expq.size()), 0);

        // 10-pixel line with a downstream stall on cycles 3..5.
        for (int i = 0; i < 10; i++) spix[i] = 12'($urandom);
        cfg_mode = 2'd1;
        acc0 = n_acc; out0 = n_out; k = 0;
        for (int c = 0; c < 60 && (n_out - out0) < 10; c++) begin
            snk_ready = !(c >= 3 && c <= 5);
            src_valid = (k < 10);
            src_sof   = (k == 0);
            src_eol   = (k == 9);
            src_rgb   = (k < 10) ? spix[k] : 12'h000;
            #1;
            if (c >= 3 && c <= 5) chk("stall_src_ready", 32'(src_ready), 0);
            if (src_valid && src_ready) k++;
            tick();
        end
        src_valid = 1'b0; src_sof = 1'b0; src_eol = 1'b0; snk_ready = 1'b1;
        chk("stream_in_cnt",  32'(n_acc - acc0), 10);
        chk("stream_out_cnt", 32'(n_out - out0), 10);

        // Random traffic with random config and backpressure.
        for (int c = 0; c < 400; c++) begin
            src_valid = ($urandom_range(0, 3) != 0);
            snk_ready = ($urandom_range(0, 3) != 0);
            src_sof   = ($urandom_range(0, 7) == 0);
            src_eol   = ($urandom_range(0, 7) == 0);
            src_rgb   = 12'($urandom);
            cfg_mode  = 2'($urandom);
            cfg_rw    = 8'($urandom);
            cfg_gw    = 8'($urandom);
            cfg_bw    = 8'($urandom);
            tick();
        end
        src_valid = 1'b0; src_sof = 1'b0; src_eol = 1'b0; snk_ready = 1'b1;
        repeat (4) tick();
        chk("rand_drained", 32'(expq.size()), 0);
        chk("rand_balance", 32'(n_acc), 32'(n_out));

        // Reset with two pixels in flight.
        cfg_rw = 8'd53; cfg_gw = 8'd184; cfg_bw = 8'd18;
        src_valid = 1'b1; src_sof = 1'b1; cfg_mode = 2'd3; src_rgb = 12'h111;
        tick();
        src_sof = 1'b0; src_rgb = 12'h222;
        tick();
        src_valid = 1'b0; rst = 1'b1;
        tick();
        chk("rst_flight_vld", 32'(snk_valid), 0);
        rst = 1'b0;
        directed("post_rst", 2'd3, 1'b0, 12'hABC, 12'hABC);
        chk("post_rst_empty", 32'(expq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_color_xform_gen.md
Name: video_color_xform_gen

Overview:
- Streaming per-pixel colour transform with selectable mode: bypass, luminosity gray, average gray, invert.
- Valid/ready handshake with backpressure.
- Frame-synchronous mode and weight updates.
- Sits between the video source/line buffer and the VGA sync/output stage. Replaces fixed-function, always-on gray conversion in the video core pipeline.

Parameters:
- RSIZE, 4, red channel width in bits
- GSIZE, 4, green channel width in bits
- BSIZE, 4, blue channel width in bits
- RGB_SIZE, RSIZE+GSIZE+BSIZE, packed pixel width (derived)
- WSIZE, 8, weight width; weights are fixed-point fractions scaled by 2^WSIZE

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; synchronous, active-high
- cfg_mode  in  2  requested mode: 0 bypass, 1 luminosity, 2 average, 3 invert
- cfg_rw  in  WSIZE  requested red weight
- cfg_gw  in  WSIZE  requested green weight
- cfg_bw  in  WSIZE  requested blue weight
- src_valid  in  1  input pixel valid
- src_ready  out  1  input pixel accepted when src_valid && src_ready
- src_sof  in  1  start of frame, qualifies first pixel of frame
- src_eol  in  1  end of line, qualifies last pixel of line
- src_rgb  in  RGB_SIZE  input pixel {r,g,b}, r in MSBs
- snk_valid  out  1  output pixel valid
- snk_ready  in  1  downstream ready
- snk_sof  out  1  sof delayed with its pixel
- snk_eol  out  1  eol delayed with its pixel
- snk_rgb  out  RGB_SIZE  transformed pixel

Behaviour:
- Pipeline timing:
  - 2-stage pipeline: S0 register (input and operands), S1 register (result).
  - Latency is exactly 2 cycles from an accepted beat to snk_valid when not stalled.
  - Throughput is 1 pixel/clk.
- Enable and stall:
  - Global enable: en = !snk_valid || snk_ready; src_ready = en.
  - When en=0, all stage registers, valids and sideband hold. snk_* must stay stable while snk_valid && !snk_ready.
  - Bubbles propagate: a stage valid clears when en=1 and no beat enters it.
  - sof/eol travel with their pixel, never reordered or dropped.
- Configuration:
  - Active config (mode, rw, gw, bw) updates only on an accepted beat with src_sof=1; that beat and all later beats use the new config.
  - cfg changes at any other time are ignored until the next accepted sof.
- Arithmetic:
  - CW = max(RSIZE,GSIZE,BSIZE). Each channel is MSB-aligned to CW, zero-filled in the LSBs.
  - Luminosity: sum = r*rw + g*gw + b*bw, width CW+WSIZE+2. gray = sum >> WSIZE, saturated to 2^CW-1.
  - Average: sum = (r+g+b)*85 with WSIZE=8 semantics, scaled by 2^(WSIZE-8), then shifted and saturated as for luminosity.
  - Gray output: each output channel = top bits of gray truncated to that channel's width.
  - Invert: each channel is the bitwise NOT of its input.
  - Bypass: snk_rgb = src_rgb.
  - All modes take the same 2-cycle latency.
- Reset:
  - Values: snk_valid=0, snk_sof=0, snk_eol=0, snk_rgb=0, internal valids=0.
  - Active mode resets to bypass; active weights reset to 53/184/18 (scaled for WSIZE).
  - Reset mid-frame discards all in-flight pixels; no partial output.
- Boundary cases:
  - Sof with snk_ready low: the config still latches on acceptance, not on presentation.
  - Back-to-back sof beats each relatch the config.
  - All-zero weights produce gray 0.
  - Weight sum >2^WSIZE saturates, never wraps.

Optional Feature:
- Macro: VIDEO_COLOR_XFORM_ROUND_EN.
- Defined: add 2^(WSIZE-1) to sum before the shift (round-half-up), then saturate.
- Undefined: truncate. Latency is unchanged either way.

Decomposition:
- Package video_color_pkg holds:
  - mode enum (MODE_BYPASS, MODE_LUMA, MODE_AVG, MODE_INVERT)
  - default weight localparams LUMA_RW/GW/BW = 53/184/18
  - AVG_W = 85
  - the max-width helper function
- Sub-module video_color_wsum: the registered multiply-accumulate/shift/saturate stage, instantiated once with operand and weight inputs.

Test Plan:
- Luma, 4/4/4, default weights, white src_rgb=0xFFF:
  - without ROUND_EN: snk_rgb=0xEEE (3825>>8=14)
  - with ROUND_EN: 0xFFF
  - exactly 2 cycles after acceptance
- Luma, red 0xF00 -> 0x333 (795>>8=3); average 0x963 -> 0x555 ((18*85)>>8=5); invert 0x1A5 -> 0xE5A; bypass 0x1A5 -> 0x1A5.
- Streaming 10 pixels, snk_ready low for cycles 3-5:
  - src_ready low on the same cycles
  - snk_rgb/snk_sof/snk_eol hold stable
  - all 10 outputs in order, none duplicated
- cfg_mode bypass->invert mid-frame: unchanged output until the next accepted sof beat; that sof pixel is inverted.
- rst asserted with 2 pixels in flight:
  - next cycle snk_valid=0, mode bypass
  - first post-reset pixel emerges unmodified after 2 cycles
- Saturation: cfg_rw=gw=bw=255 latched on sof, pixel 0xFFF -> 0xFFF, no wrap.
